// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: mode encoding, rate lookup and domain-suffix bytes.
package keccak_pkg;

    localparam int LANE_W    = 64;
    localparam int MAX_RATE  = 1344;
    localparam int NUM_MODES = 6;

    localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
    localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;

    typedef enum logic [2:0] {
        MODE_SHA3_224 = 3'd0,
        MODE_SHA3_256 = 3'd1,
        MODE_SHA3_384 = 3'd2,
        MODE_SHA3_512 = 3'd3,
        MODE_SHAKE128 = 3'd4,
        MODE_SHAKE256 = 3'd5
    } keccak_mode_e;

    function automatic logic [4:0] rate_lanes(input logic [2:0] mode);
        case (mode)
            MODE_SHA3_224: return 5'd18;
            MODE_SHA3_256: return 5'd17;
            MODE_SHA3_384: return 5'd13;
            MODE_SHA3_512: return 5'd9;
            MODE_SHAKE128: return 5'd21;
            default:       return 5'd17;
        endcase
    endfunction

    function automatic logic [7:0] suffix_byte(input logic [2:0] mode);
        return (mode >= MODE_SHAKE128) ? SUFFIX_SHAKE : SUFFIX_SHA3;
    endfunction

endpackage

// File: rtl/keccak_pad_absorb_if.sv
// Host word stream in, rate-sized block stream out. master = host/consumer side, slave = absorb stage.
interface keccak_pad_absorb_if #(
    parameter int LANE_W   = keccak_pkg::LANE_W,
    parameter int MAX_RATE = keccak_pkg::MAX_RATE
);
    logic [2:0]          c_mode;
    logic                in_valid;
    logic                in_ready;
    logic [LANE_W-1:0]   in_data;
    logic                in_last;
    logic [3:0]          in_nbytes;
    logic                block_valid;
    logic                block_ready;
    logic [MAX_RATE-1:0] block_data;
    logic                block_last;
    logic [2:0]          mode_o;

    modport master (
        output c_mode, in_valid, in_data, in_last, in_nbytes, block_ready,
        input  in_ready, block_valid, block_data, block_last, mode_o
    );

    modport slave (
        input  c_mode, in_valid, in_data, in_last, in_nbytes, block_ready,
        output in_ready, block_valid, block_data, block_last, mode_o
    );
endinterface

// File: rtl/keccak_lane_pad.sv
// Masks a final message lane to its valid bytes and drops the domain suffix at byte n.
module keccak_lane_pad
    import keccak_pkg::*;
(
    input  logic [LANE_W-1:0] word,
    input  logic              last,
    input  logic [3:0]        nbytes,
    input  logic [7:0]        suffix,
    output logic [LANE_W-1:0] lane
);
    for (genvar gi = 0; gi < LANE_W / 8; gi++) begin : g_byte
        // nbytes is already clamped to 0..8, so n=8 keeps the whole lane and places no suffix here
        assign lane[8*gi +: 8] = !last                  ? word[8*gi +: 8] :
                                 (4'(gi) < nbytes)      ? word[8*gi +: 8] :
                                 (4'(gi) == nbytes)     ? suffix          : 8'h00;
    end
endmodule

// File: rtl/keccak_pad_absorb.sv
// Absorb stage: packs 64-bit words into a rate block, applies suffix + pad10*1, hands blocks downstream.
module keccak_pad_absorb #(
    parameter int LANE_W   = keccak_pkg::LANE_W,
    parameter int MAX_RATE = keccak_pkg::MAX_RATE
) (
    input logic clk,
    input logic rst,
    keccak_pad_absorb_if.slave bus
);
    import keccak_pkg::rate_lanes;
    import keccak_pkg::suffix_byte;
    import keccak_pkg::NUM_MODES;

    localparam int NUM_LANES = MAX_RATE / LANE_W;
    localparam int IDX_W     = $clog2(NUM_LANES + 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD, S_PADBLK} state_e;

    state_e                              state_reg;
    logic [2:0]                          mode_reg;
    logic [IDX_W-1:0]                    lane_idx_reg;
    logic                                pad_pending_reg;
    logic                                valid_reg;
    logic                                last_reg;
    logic [NUM_LANES-1:0][LANE_W-1:0]    buf_reg;
    logic [NUM_LANES-1:0][LANE_W-1:0]    buf_next;

    logic [2:0]        cur_mode;
    logic [IDX_W-1:0]  rate;
    logic [7:0]        suffix;
    logic              accept;
    logic [IDX_W-1:0]  wr_idx;
    logic [3:0]        n_clamp;
    logic              at_end;
    logic              suffix_spills;
    logic              defer_pad;
    logic              hold_done;
    logic [LANE_W-1:0] padded_word;

    // The first word of a message is sized by the live c_mode; everything after uses the latched mode.
    assign cur_mode      = (state_reg == S_IDLE) ? bus.c_mode : mode_reg;
    assign rate          = IDX_W'(rate_lanes(cur_mode));
    assign suffix        = suffix_byte(cur_mode);
    assign bus.in_ready  = (state_reg == S_FILL) ||
                           ((state_reg == S_IDLE) && (bus.c_mode < 3'(NUM_MODES)));
    assign accept        = bus.in_valid && bus.in_ready;
    assign wr_idx        = (state_reg == S_IDLE) ? '0 : lane_idx_reg;
    assign n_clamp       = (bus.in_nbytes > 4'd8) ? 4'd8 : bus.in_nbytes;
    assign at_end        = (wr_idx == rate - 1'b1);
    assign suffix_spills = bus.in_last && (n_clamp == 4'd8);
    // A full final word in the last lane leaves no room; the padding moves to an extra block.
    assign defer_pad     = suffix_spills && at_end;
    assign hold_done     = (state_reg == S_HOLD) && bus.block_ready;

    keccak_lane_pad u_lane_pad (
        .word   (bus.in_data),
        .last   (bus.in_last),
        .nbytes (n_clamp),
        .suffix (suffix),
        .lane   (padded_word)
    );

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        localparam logic [IDX_W-1:0] LANE_IDX = IDX_W'(gi);
        logic [LANE_W-1:0] lane_next;

        always_comb begin
            lane_next = buf_reg[gi];
            if (hold_done) begin
                lane_next = '0;
            end else if (state_reg == S_PADBLK) begin
                if (gi == 0) lane_next[7:0] = suffix;
                if (LANE_IDX == rate - 1'b1) lane_next[LANE_W-1 -: 8] = lane_next[LANE_W-1 -: 8] | 8'h80;
            end else if (accept) begin
                if (LANE_IDX == wr_idx) lane_next = padded_word;
                if (suffix_spills && !defer_pad && (LANE_IDX == wr_idx + 1'b1)) lane_next[7:0] = suffix;
                if (bus.in_last && !defer_pad && (LANE_IDX == rate - 1'b1))
                    lane_next[LANE_W-1 -: 8] = lane_next[LANE_W-1 -: 8] | 8'h80;
            end
        end

        assign buf_next[gi] = lane_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            mode_reg        <= '0;
            lane_idx_reg    <= '0;
            pad_pending_reg <= 1'b0;
            valid_reg       <= 1'b0;
            last_reg        <= 1'b0;
            buf_reg         <= '0;
        end else begin
            buf_reg <= buf_next;
            case (state_reg)
                S_IDLE, S_FILL: begin
                    if (accept) begin
                        if (state_reg == S_IDLE) mode_reg <= bus.c_mode;
                        lane_idx_reg <= wr_idx + 1'b1;
                        if (bus.in_last || at_end) begin
                            state_reg       <= S_HOLD;
                            valid_reg       <= 1'b1;
                            last_reg        <= bus.in_last && !defer_pad;
                            pad_pending_reg <= defer_pad;
                        end else begin
                            state_reg <= S_FILL;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.block_ready) begin
                        valid_reg    <= 1'b0;
                        last_reg     <= 1'b0;
                        lane_idx_reg <= '0;
                        if (pad_pending_reg)  state_reg <= S_PADBLK;
                        else if (last_reg)    state_reg <= S_IDLE;
                        else                  state_reg <= S_FILL;
                    end
                end
                S_PADBLK: begin
                    pad_pending_reg <= 1'b0;
                    last_reg        <= 1'b1;
                    valid_reg       <= 1'b1;
                    state_reg       <= S_HOLD;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.block_valid = valid_reg;
    assign bus.block_data  = buf_reg;
    assign bus.block_last  = last_reg;
    assign bus.mode_o      = mode_reg;
endmodule

// File: tb/tb_keccak_pad_absorb.sv
// Bench for keccak_pad_absorb: byte-stream FIPS 202 padding model plus literal pins on that model.
module tb_keccak_pad_absorb;
    localparam int RB = 1344;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [RB-1:0] data;
        logic          last;
        logic [2:0]    mode;
    } blk_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keccak_pad_absorb_if bus ();
    keccak_pad_absorb dut (.clk(clk), .rst(rst), .bus(bus.slave));

    blk_t        exp_q[$];
    logic [63:0] cur_words[$];
    int          cur_mode;
    int          cur_last_n;
    int          checks = 0;
    int          errors = 0;
    int          stall  = 0;
    int          seed   = 0;
    int          blk_cnt = 0;
    int          rate_tab[6] = '{18, 17, 13, 9, 21, 17};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic chk_data(input string name, input logic [RB-1:0] got, input logic [RB-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            for (int l = 0; l < RB / 64; l++) begin
                if (got[64*l +: 64] !== want[64*l +: 64]) begin
                    $display("FAIL %s lane %0d got=%h want=%h", name, l, got[64*l +: 64], want[64*l +: 64]);
                    break;
                end
            end
        end
    endtask

    // Plain FIPS 202 byte-level padding: msg || suffix || 0* with 0x80 OR'd into the last rate byte.
    task automatic model_msg(input int mode, input bq_t msg);
        int   rbytes = rate_tab[mode] * 8;
        bq_t  b = msg;
        int   nblk;
        b.push_back(mode < 4 ? 8'h06 : 8'h1F);
        while (b.size() % rbytes != 0) b.push_back(8'h00);
        b[b.size() - 1] = b[b.size() - 1] | 8'h80;
        nblk = b.size() / rbytes;
        for (int k = 0; k < nblk; k++) begin
            blk_t e;
            e.data = '0;
            for (int i = 0; i < rbytes; i++) e.data[8*i +: 8] = b[k*rbytes + i];
            e.last = (k == nblk - 1);
            e.mode = 3'(mode);
            exp_q.push_back(e);
        end
    endtask

    task automatic build_msg(input int mode, input int nwords, input int last_n, input logic [63:0] w0);
        bq_t msg;
        int  n = (last_n > 8) ? 8 : last_n;
        cur_words.delete();
        seed++;
        for (int w = 0; w < nwords; w++) begin
            logic [63:0] word;
            for (int k = 0; k < 8; k++) word[8*k +: 8] = 8'(seed * 29 + w * 8 + k + 3);
            if (nwords == 1) word = w0;
            cur_words.push_back(word);
            for (int k = 0; k < 8; k++)
                if (w < nwords - 1 || k < n) msg.push_back(word[8*k +: 8]);
        end
        cur_mode   = mode;
        cur_last_n = last_n;
        model_msg(mode, msg);
    endtask

    task automatic send_word(input int mode, input logic [63:0] d, input logic last, input logic [3:0] n);
        bit rdy;
        int budget = 300;
        bus.c_mode    = 3'(mode);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = last;
        bus.in_nbytes = n;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            budget--;
        end while (!rdy && budget > 0);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL in_handshake got no in_ready within budget required accept");
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Later words drive an out-of-range c_mode: it must be ignored mid-message.
    task automatic drive_msg(input int stall_c);
        stall = stall_c;
        for (int w = 0; w < cur_words.size(); w++)
            send_word(w == 0 ? cur_mode : 7, cur_words[w], w == cur_words.size() - 1, 4'(cur_last_n));
    endtask

    task automatic drain();
        int budget = 3000;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        chk("drain_remaining_blocks", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt = 0;
        bus.block_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.block_valid) begin
                bus.block_ready = (cnt >= stall);
                cnt++;
            end else begin
                bus.block_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.block_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block got block_valid=1 required 0");
                end else begin
                    chk_data("block_data", bus.block_data, exp_q[0].data);
                    chk("block_last", 64'(bus.block_last), 64'(exp_q[0].last));
                    chk("mode_o", 64'(bus.mode_o), 64'(exp_q[0].mode));
                    chk("in_ready_in_hold", 64'(bus.in_ready), 64'd0);
                    if (bus.block_ready) begin
                        $display("block %0d mode %0d last %0b", blk_cnt, bus.mode_o, bus.block_last);
                        blk_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.c_mode    = 3'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_nbytes = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_block_valid", 64'(bus.block_valid), 64'd0);
        chk("reset_block_last", 64'(bus.block_last), 64'd0);
        chk("reset_mode_o", 64'(bus.mode_o), 64'd0);
        chk_data("reset_block_data", bus.block_data, '0);
        chk("idle_in_ready_mode0", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // SHA3-256 empty message; garbage data must be masked away
        build_msg(1, 1, 0, 64'hDEAD_BEEF_CAFE_F00D);
        chk("pin_empty_nblk", 64'(exp_q.size()), 64'd1);
        chk("pin_empty_byte0", 64'(exp_q[0].data[7:0]), 64'h06);
        chk("pin_empty_byte135", 64'(exp_q[0].data[135*8 +: 8]), 64'h80);
        chk("pin_empty_ones", 64'($countones(exp_q[0].data)), 64'd3);
        drive_msg(0);
        drain();

        // SHAKE128 "abc"
        build_msg(4, 1, 3, 64'h0000_0000_0063_6261);
        chk("pin_abc_low", 64'(exp_q[0].data[31:0]), 64'h1F63_6261);
        chk("pin_abc_byte167", 64'(exp_q[0].data[167*8 +: 8]), 64'h80);
        drive_msg(1);
        drain();

        // SHA3-512 full-rate final word: padding spills into a second block
        build_msg(3, 9, 8, '0);
        chk("pin_512full_nblk", 64'(exp_q.size()), 64'd2);
        chk("pin_512full_last0", 64'(exp_q[0].last), 64'd0);
        chk("pin_512full_b1byte0", 64'(exp_q[1].data[7:0]), 64'h06);
        chk("pin_512full_b1byte71", 64'(exp_q[1].data[71*8 +: 8]), 64'h80);
        drive_msg(2);
        drain();

        // Suffix and final pad bit share the last byte
        build_msg(3, 9, 7, '0);
        chk("pin_512n7_byte71", 64'(exp_q[0].data[71*8 +: 8]), 64'h86);
        drive_msg(0);
        drain();

        build_msg(5, 17, 7, '0);
        chk("pin_shake256_byte135", 64'(exp_q[0].data[135*8 +: 8]), 64'h9F);
        drive_msg(0);
        drain();

        // in_nbytes above 8 behaves as 8
        build_msg(1, 2, 12, '0);
        chk("pin_n12_byte16", 64'(exp_q[0].data[16*8 +: 8]), 64'h06);
        drive_msg(0);
        drain();

        // SHA3-224 40 words with 10-cycle downstream stalls
        build_msg(0, 40, 8, '0);
        chk("pin_224_nblk", 64'(exp_q.size()), 64'd3);
        chk("pin_224_b2lane4", 64'(exp_q[2].data[4*64 +: 8]), 64'h06);
        drive_msg(10);
        drain();

        // Reset in the middle of a partial block
        stall = 0;
        send_word(3, 64'h1122_3344_5566_7788, 1'b0, 4'd0);
        send_word(7, 64'h99AA_BBCC_DDEE_FF00, 1'b0, 4'd0);
        #2 rst = 1'b1;
        #1;
        chk("midreset_block_valid", 64'(bus.block_valid), 64'd0);
        chk("midreset_mode_o", 64'(bus.mode_o), 64'd0);
        chk_data("midreset_block_data", bus.block_data, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Unsupported mode is never accepted
        bus.c_mode    = 3'd6;
        bus.in_valid  = 1'b1;
        bus.in_last   = 1'b1;
        bus.in_nbytes = 4'd0;
        repeat (3) begin
            @(negedge clk);
            chk("mode6_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;

        build_msg(1, 1, 3, 64'h0000_0000_0063_6261);
        chk("pin_abc256_low", 64'(exp_q[0].data[31:0]), 64'h0663_6261);
        drive_msg(0);
        drain();

        chk("total_blocks", 64'(blk_cnt), 64'd11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
